// File: rtl/dccm_resp.sv
// -----------------------------------------------------------------------------
// dccm_resp -- data closely-coupled memory with a registered read response.
//
// After reset the block walks every word and writes zero, one per cycle
// (INIT). It then enters READY and serves single-word reads and writes from
// the load/store unit. Reads have a fixed one-cycle latency and are fully
// pipelined. A same-edge read and write to the same word returns the new write
// data. Out-of-range reads still respond, with zero data. Out-of-range writes
// are dropped. Either kind of out-of-range access raises a one-cycle error
// pulse.
//
// Ports
//   clk                  single clock, rising edge
//   rst                  asynchronous, active-high reset
//   lsu_dccm_raddr       read byte address (addr[1:0] ignored)
//   lsu_dccm_rvalid_in   read request strobe
//   lsu_dccm_rdata       read data, held until the next response
//   lsu_dccm_rvalid_out  one-cycle pulse per accepted read
//   lsu_dccm_waddr       write byte address (addr[1:0] ignored)
//   lsu_dccm_wen         full-word write strobe
//   lsu_dccm_wdata       write data
//   dccm_init_done       high once the post-reset clear has completed
//   dccm_addr_err        one-cycle pulse after any out-of-range access
// -----------------------------------------------------------------------------
module dccm_resp #(
  parameter int               XLEN      = 32,
  parameter logic [XLEN-1:0]  DCCM_BASE = '0,
  parameter int               DEPTH     = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] lsu_dccm_raddr,
  input  logic            lsu_dccm_rvalid_in,
  output logic [XLEN-1:0] lsu_dccm_rdata,
  output logic            lsu_dccm_rvalid_out,
  input  logic [XLEN-1:0] lsu_dccm_waddr,
  input  logic            lsu_dccm_wen,
  input  logic [XLEN-1:0] lsu_dccm_wdata,
  output logic            dccm_init_done,
  output logic            dccm_addr_err
);

  localparam int AW = $clog2(DEPTH);

  // One extra bit so the upper bound cannot wrap when the DCCM sits at the
  // top of the address space.
  localparam logic [XLEN:0] BASE_EXT  = {1'b0, DCCM_BASE};
  localparam logic [XLEN:0] LIMIT_EXT = BASE_EXT + (XLEN+1)'(4 * DEPTH);

  typedef enum logic {INIT, READY} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   clr_cnt;
  logic            clr_last;
  logic            clr_en;
  logic            ready;

  logic [XLEN-1:0] mem [DEPTH];

  logic            rd_in_range, wr_in_range;
  logic [AW-1:0]   rd_idx, wr_idx;
  logic            rd_acc, wr_acc, wr_ok;

  function automatic logic in_range(input logic [XLEN-1:0] addr);
    return ({1'b0, addr} >= BASE_EXT) && ({1'b0, addr} < LIMIT_EXT);
  endfunction

  // Byte offset from the base, divided by four, truncated to the word index.
  function automatic logic [AW-1:0] word_idx(input logic [XLEN-1:0] addr);
    return AW'((addr - DCCM_BASE) >> 2);
  endfunction

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of its neighbours; blocking here would create order races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= INIT;
      clr_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (clr_en) clr_cnt <= clr_cnt + 1'b1;
    end
  end

  assign clr_last = (clr_cnt == AW'(DEPTH - 1));

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment at the top of each always_comb guarantees
  // every path drives the signal, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      INIT:    if (clr_last) state_nxt = READY;
      READY:   state_nxt = READY;
      default: state_nxt = INIT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (decoded from the state flop only)
  // ---------------------------------------------------------------------------
  always_comb begin
    clr_en         = 1'b0;
    ready          = 1'b0;
    dccm_init_done = 1'b0;
    unique case (state)
      INIT:    clr_en = 1'b1;
      READY: begin
        ready          = 1'b1;
        dccm_init_done = 1'b1;
      end
      default: clr_en = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  assign rd_in_range = in_range(lsu_dccm_raddr);
  assign wr_in_range = in_range(lsu_dccm_waddr);
  assign rd_idx      = word_idx(lsu_dccm_raddr);
  assign wr_idx      = word_idx(lsu_dccm_waddr);

  assign rd_acc = ready && lsu_dccm_rvalid_in;
  assign wr_acc = ready && lsu_dccm_wen;
  assign wr_ok  = wr_acc && wr_in_range;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset; the INIT sweep zeroes it instead, which
  // keeps it mappable onto a RAM macro.
  always_ff @(posedge clk) begin
    if (clr_en)     mem[clr_cnt] <= '0;
    else if (wr_ok) mem[wr_idx]  <= lsu_dccm_wdata;
  end

  // ---------------------------------------------------------------------------
  // Read response and error pulse
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lsu_dccm_rdata      <= '0;
      lsu_dccm_rvalid_out <= 1'b0;
      dccm_addr_err       <= 1'b0;
    end else begin
      lsu_dccm_rvalid_out <= rd_acc;
      dccm_addr_err       <= (rd_acc && !rd_in_range) || (wr_acc && !wr_in_range);
      if (rd_acc) begin
        if (!rd_in_range)
          lsu_dccm_rdata <= '0;
        else if (wr_ok && (wr_idx == rd_idx))
          lsu_dccm_rdata <= lsu_dccm_wdata;   // write-first bypass
        else
          lsu_dccm_rdata <= mem[rd_idx];
      end
    end
  end

endmodule

// File: tb/tb_dccm_resp.sv
module tb_dccm_resp;

  localparam int              XLEN  = 32;
  localparam int              DEPTH = 16;
  localparam logic [31:0]     BASE  = 32'h1000;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [XLEN-1:0] lsu_dccm_raddr = '0;
  logic            lsu_dccm_rvalid_in = 1'b0;
  logic [XLEN-1:0] lsu_dccm_rdata;
  logic            lsu_dccm_rvalid_out;
  logic [XLEN-1:0] lsu_dccm_waddr = '0;
  logic            lsu_dccm_wen = 1'b0;
  logic [XLEN-1:0] lsu_dccm_wdata = '0;
  logic            dccm_init_done;
  logic            dccm_addr_err;

  int vectors    = 0;
  int miscompares = 0;

  dccm_resp #(.XLEN(XLEN), .DCCM_BASE(BASE), .DEPTH(DEPTH)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .lsu_dccm_raddr      (lsu_dccm_raddr),
    .lsu_dccm_rvalid_in  (lsu_dccm_rvalid_in),
    .lsu_dccm_rdata      (lsu_dccm_rdata),
    .lsu_dccm_rvalid_out (lsu_dccm_rvalid_out),
    .lsu_dccm_waddr      (lsu_dccm_waddr),
    .lsu_dccm_wen        (lsu_dccm_wen),
    .lsu_dccm_wdata      (lsu_dccm_wdata),
    .dccm_init_done      (dccm_init_done),
    .dccm_addr_err       (dccm_addr_err)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    lsu_dccm_rvalid_in = 1'b0;
    lsu_dccm_wen       = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    vectors++;
    if (lsu_dccm_rdata !== 32'h0 || lsu_dccm_rvalid_out !== 1'b0 ||
        dccm_addr_err !== 1'b0 || dccm_init_done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: rdata=%h rvalid=%b err=%b done=%b, required 0/0/0/0",
               lsu_dccm_rdata, lsu_dccm_rvalid_out, dccm_addr_err, dccm_init_done);
    end
  endtask

  // Release reset with a read held on word 0; done must rise on edge 16 exactly.
  task automatic test_init();
    lsu_dccm_rvalid_in = 1'b1;
    lsu_dccm_raddr     = BASE;
    rst = 1'b0;
    for (int i = 1; i <= DEPTH; i++) begin
      step();
      vectors++;
      if (dccm_init_done !== (i == DEPTH)) begin
        miscompares++;
        $display("FAIL init_done_cycle%0d: got %b, required %b", i, dccm_init_done, (i == DEPTH));
      end
      vectors++;
      if (lsu_dccm_rvalid_out !== 1'b0 || dccm_addr_err !== 1'b0) begin
        miscompares++;
        $display("FAIL init_quiet_cycle%0d: rvalid=%b err=%b, required 0/0",
                 i, lsu_dccm_rvalid_out, dccm_addr_err);
      end
    end
    // First READY edge accepts the held read; word 0 was cleared.
    step();
    vectors++;
    if (lsu_dccm_rvalid_out !== 1'b1 || lsu_dccm_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL init_first_read: rvalid=%b rdata=%h, required 1/00000000",
               lsu_dccm_rvalid_out, lsu_dccm_rdata);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_write_read();
    lsu_dccm_wen   = 1'b1;
    lsu_dccm_waddr = 32'h1004;
    lsu_dccm_wdata = 32'hDEAD_BEEF;
    step();
    lsu_dccm_wen       = 1'b0;
    lsu_dccm_rvalid_in = 1'b1;
    lsu_dccm_raddr     = 32'h1004;
    step();
    vectors++;
    if (lsu_dccm_rvalid_out !== 1'b1 || lsu_dccm_rdata !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL read_1004: rvalid=%b rdata=%h, required 1/deadbeef",
               lsu_dccm_rvalid_out, lsu_dccm_rdata);
    end
    lsu_dccm_raddr = 32'h1007;
    step();
    vectors++;
    if (lsu_dccm_rvalid_out !== 1'b1 || lsu_dccm_rdata !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL read_1007_unaligned: rvalid=%b rdata=%h, required 1/deadbeef",
               lsu_dccm_rvalid_out, lsu_dccm_rdata);
    end
    idle_inputs();
    step();
    vectors++;
    if (lsu_dccm_rvalid_out !== 1'b0 || lsu_dccm_rdata !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL rdata_hold: rvalid=%b rdata=%h, required 0/deadbeef",
               lsu_dccm_rvalid_out, lsu_dccm_rdata);
    end
  endtask

  task automatic test_bypass();
    // Same word: new data must come back.
    lsu_dccm_wen       = 1'b1;
    lsu_dccm_waddr     = 32'h1008;
    lsu_dccm_wdata     = 32'h1234_5678;
    lsu_dccm_rvalid_in = 1'b1;
    lsu_dccm_raddr     = 32'h1008;
    step();
    vectors++;
    if (lsu_dccm_rvalid_out !== 1'b1 || lsu_dccm_rdata !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL bypass_same_word: rvalid=%b rdata=%h, required 1/12345678",
               lsu_dccm_rvalid_out, lsu_dccm_rdata);
    end
    // Different words: read sees its own old contents.
    lsu_dccm_waddr = 32'h1008;
    lsu_dccm_wdata = 32'hAAAA_5555;
    lsu_dccm_raddr = 32'h1004;
    step();
    vectors++;
    if (lsu_dccm_rdata !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL bypass_other_word: rdata=%h, required deadbeef", lsu_dccm_rdata);
    end
    // Confirm the different-word write landed.
    lsu_dccm_wen   = 1'b0;
    lsu_dccm_raddr = 32'h1008;
    step();
    vectors++;
    if (lsu_dccm_rdata !== 32'hAAAA_5555) begin
      miscompares++;
      $display("FAIL bypass_write_landed: rdata=%h, required aaaa5555", lsu_dccm_rdata);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_out_of_range();
    // 0x0FFC aliases word 15 if the range check were missing.
    lsu_dccm_rvalid_in = 1'b1;
    lsu_dccm_raddr     = 32'h1040;
    lsu_dccm_wen       = 1'b1;
    lsu_dccm_waddr     = 32'h0FFC;
    lsu_dccm_wdata     = 32'h5555_AAAA;
    step();
    vectors++;
    if (lsu_dccm_rvalid_out !== 1'b1 || lsu_dccm_rdata !== 32'h0 || dccm_addr_err !== 1'b1) begin
      miscompares++;
      $display("FAIL oor_response: rvalid=%b rdata=%h err=%b, required 1/00000000/1",
               lsu_dccm_rvalid_out, lsu_dccm_rdata, dccm_addr_err);
    end
    idle_inputs();
    step();
    vectors++;
    if (dccm_addr_err !== 1'b0 || lsu_dccm_rvalid_out !== 1'b0) begin
      miscompares++;
      $display("FAIL oor_single_pulse: err=%b rvalid=%b, required 0/0",
               dccm_addr_err, lsu_dccm_rvalid_out);
    end
    lsu_dccm_rvalid_in = 1'b1;
    lsu_dccm_raddr     = 32'h103C;
    step();
    vectors++;
    if (lsu_dccm_rvalid_out !== 1'b1 || lsu_dccm_rdata !== 32'h0 || dccm_addr_err !== 1'b0) begin
      miscompares++;
      $display("FAIL oor_write_dropped: rvalid=%b rdata=%h err=%b, required 1/00000000/0",
               lsu_dccm_rvalid_out, lsu_dccm_rdata, dccm_addr_err);
    end
    // Out-of-range write alone also pulses the error.
    lsu_dccm_rvalid_in = 1'b0;
    lsu_dccm_wen       = 1'b1;
    lsu_dccm_waddr     = 32'h1040;
    step();
    vectors++;
    if (dccm_addr_err !== 1'b1 || lsu_dccm_rvalid_out !== 1'b0) begin
      miscompares++;
      $display("FAIL oor_write_err: err=%b rvalid=%b, required 1/0",
               dccm_addr_err, lsu_dccm_rvalid_out);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3];
    addrs[0] = 32'h1000;
    addrs[1] = 32'h1004;
    addrs[2] = 32'h1008;
    lsu_dccm_wen = 1'b1;
    for (int i = 0; i < 3; i++) begin
      lsu_dccm_waddr = addrs[i];
      lsu_dccm_wdata = 32'(i + 1);
      step();
    end
    lsu_dccm_wen       = 1'b0;
    lsu_dccm_rvalid_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      lsu_dccm_raddr = addrs[i];
      step();
      vectors++;
      if (lsu_dccm_rvalid_out !== 1'b1 || lsu_dccm_rdata !== 32'(i + 1)) begin
        miscompares++;
        $display("FAIL b2b_read%0d: rvalid=%b rdata=%h, required 1/%h",
                 i, lsu_dccm_rvalid_out, lsu_dccm_rdata, 32'(i + 1));
      end
    end
    idle_inputs();
    step();
    vectors++;
    if (lsu_dccm_rvalid_out !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_end: rvalid=%b, required 0", lsu_dccm_rvalid_out);
    end
  endtask

  task automatic test_reset_abort();
    lsu_dccm_wen   = 1'b1;
    lsu_dccm_waddr = 32'h1000;
    lsu_dccm_wdata = 32'h0000_00FF;
    step();
    lsu_dccm_wen       = 1'b0;
    lsu_dccm_rvalid_in = 1'b1;
    lsu_dccm_raddr     = 32'h1000;
    // Request is accepted at the next edge; reset hits before the response
    // would be sampled and must clear it without waiting for a clock.
    @(posedge clk);
    rst = 1'b1;
    #1;
    idle_inputs();
    vectors++;
    if (lsu_dccm_rvalid_out !== 1'b0 || dccm_init_done !== 1'b0 || lsu_dccm_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL abort_async: rvalid=%b done=%b rdata=%h, required 0/0/00000000",
               lsu_dccm_rvalid_out, dccm_init_done, lsu_dccm_rdata);
    end
    step();
    rst = 1'b0;
    for (int i = 1; i <= DEPTH; i++) begin
      step();
      vectors++;
      if (dccm_init_done !== (i == DEPTH) || lsu_dccm_rvalid_out !== 1'b0) begin
        miscompares++;
        $display("FAIL reinit_cycle%0d: done=%b rvalid=%b, required %b/0",
                 i, dccm_init_done, lsu_dccm_rvalid_out, (i == DEPTH));
      end
    end
    lsu_dccm_rvalid_in = 1'b1;
    lsu_dccm_raddr     = 32'h1000;
    step();
    vectors++;
    if (lsu_dccm_rvalid_out !== 1'b1 || lsu_dccm_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reinit_cleared: rvalid=%b rdata=%h, required 1/00000000",
               lsu_dccm_rvalid_out, lsu_dccm_rdata);
    end
    idle_inputs();
    step();
  endtask

  initial begin
    test_reset();
    test_init();
    test_write_read();
    test_bypass();
    test_out_of_range();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
